pipe_chain: RTL and testbench
=============================

# pipe_chain

Parametrised, generic pipeline-register chain that replaces the hand-written per-boundary stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a `DATA_W`-bit payload through `STAGES` registered stages and adds features the fixed registers lack:

- a per-stage valid bit;
- per-stage stall, with upstream propagation and bubble insertion;
- per-stage flush;
- a halt marker that travels with the data and drains the chain;
- an optional enabled-cycle counter.

It sits between the core's datapath stages and the hazard/debug control.

## Interface
Parameters:
- `DATA_W`, 32, payload width per stage.
- `STAGES`, 4, number of register stages (≥2).
- `CNT_W`, 32, width of the cycle counter.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  global advance enable (debug step/run); low freezes all state.
- `i_in_valid`  in  1  input payload valid.
- `i_in_data`  in  `DATA_W`  input payload.
- `i_in_halt`  in  1  input is the halt marker (qualified by `i_in_valid`).
- `i_stall`  in  `STAGES`  bit k: stage k must hold.
- `i_flush`  in  `STAGES`  bit k: stage k becomes a bubble.
- `o_in_ready`  out  1  input is accepted this edge.
- `o_stage_valid`  out  `STAGES`  valid bit of every stage.
- `o_stage_data`  out  `STAGES*DATA_W`  all stage payloads; stage k occupies `[k*DATA_W +: DATA_W]`.
- `o_out_valid`  out  1  last stage valid.
- `o_out_data`  out  `DATA_W`  last stage payload.
- `o_drained`  out  1  no stage valid.
- `o_halt`  out  1  sticky; the halt marker has left the last stage.
- `o_cycle_cnt`  out  `CNT_W`  enabled cycles since reset (see Configuration).

## Operation
- Definition: `hold[k]` = OR of `i_stall[j]` for all j ≥ k. A stall freezes its own stage and every upstream stage.
- `o_in_ready` = `i_enable` & ~`hold[0]` & ~`i_flush[0]` & ~(OR of stage halt bits) & ~`o_halt`.
- Stage k update per edge when `i_enable`=1, in priority order:
  1. `i_flush[k]` → valid=0 and halt=0; data unchanged.
  2. `hold[k]` → hold valid, halt and data.
  3. k=0 → valid = `i_in_valid` & `o_in_ready`; data = `i_in_data`; halt = `i_in_halt` & valid.
  4. `i_stall[k-1]` → bubble: valid=0, halt=0.
  5. Otherwise load from stage k-1.
- Flushing a stage that holds the halt marker discards the marker; input acceptance resumes on the following cycle.
- `o_halt` sets on an edge where `i_enable`, stage `STAGES-1` is valid, its halt bit is set, and ~`i_stall[STAGES-1]`. It is cleared only by reset.
- Once `o_halt`=1, no input is accepted. Payload already in the chain continues to advance, so the chain drains and `o_drained` rises.
- `i_enable`=0: no state changes at all, including the counter; `i_stall` and `i_flush` are ignored.
- `o_out_valid`, `o_out_data`, `o_stage_*` and `o_drained` are direct register decodes; there is no combinational path from the inputs to them.

## Timing
- Latency: an accepted input appears on `o_out_*` exactly `STAGES` enabled edges later when no stall is applied. Each stall cycle on any stage at or downstream of the item's position adds one cycle.
- Throughput: one item per enabled cycle.
- `o_in_ready` is combinational from `i_enable`, `i_stall` and `i_flush`.
- Reset (async assert, synchronous-safe deassert by the system): all valid and halt bits = 0, all data = 0, `o_halt`=0, `o_cycle_cnt`=0, `o_drained`=1. Reset asserted mid-stall or mid-drain returns the block to this state immediately.
- Simultaneous `i_stall[k]` and `i_flush[k]`: flush wins for stage k; stages below k still hold.
- `i_stall` on the last stage with a valid halt marker there: `o_halt` is deferred until the stall releases.

## Configuration
- `PIPE_CHAIN_CYCLE_CNT_EN` defined: `o_cycle_cnt` increments on every edge with `i_enable`=1 and `o_halt`=0. It wraps modulo 2^`CNT_W` and freezes once halted.
- Macro undefined: the counter is not built and `o_cycle_cnt` is tied to 0.

## Test plan
All scenarios use `STAGES`=4.
- Stream: inputs 1..8 with `i_in_valid`=1 → `o_out_data` = 1..8 on cycles 4..11, `o_out_valid` continuous.
- Stall: `i_stall[2]`=1 for 2 cycles while the chain is full → stages 0–2 frozen, stage 3 shows a 2-cycle bubble, `o_in_ready`=0 for 2 cycles, no item lost or duplicated.
- Flush plus stall on stage 1 in the same cycle → stage 1 becomes invalid, stage 0 holds, and that item exits one cycle later than unstalled.
- Halt: item 5 with `i_in_halt`=1 → `o_in_ready` drops the cycle after acceptance; `o_halt`=1 four cycles later; `o_drained`=1 once the remaining items leave.
- Flush of the halt marker at stage 2 → `o_halt` stays 0 and `o_in_ready` returns to 1 the next cycle.
- Async reset mid-stream with `i_enable` toggling → all outputs reach their reset values without a clock edge; with the macro defined, `o_cycle_cnt` counts only enabled cycles.

Source files
------------

// File: rtl/pipe_chain.sv
// -----------------------------------------------------------------------------
// pipe_chain
//   Generic pipeline-register chain carrying a DATA_W-bit payload through
//   STAGES registered stages, with per-stage valid, stall (held upstream,
//   bubble inserted downstream), flush, and a travelling halt marker that
//   drains the chain. Sits between the datapath stages and hazard/debug
//   control.
//
//   Optional feature macro: PIPE_CHAIN_CYCLE_CNT_EN
//     defined   -> o_cycle_cnt counts enabled, not-yet-halted cycles
//     undefined -> counter not built, o_cycle_cnt tied to 0
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_enable       global advance enable; low freezes all state
//   i_in_valid     input payload valid
//   i_in_data      input payload
//   i_in_halt      input is the halt marker (qualified by i_in_valid)
//   i_stall[k]     stage k must hold (also holds every stage upstream of k)
//   i_flush[k]     stage k becomes a bubble
//   o_in_ready     input accepted on this edge (combinational)
//   o_stage_valid  valid bit of every stage
//   o_stage_data   all stage payloads, stage k at [k*DATA_W +: DATA_W]
//   o_out_valid    last stage valid
//   o_out_data     last stage payload
//   o_drained      no stage valid
//   o_halt         sticky: halt marker has left the last stage
//   o_cycle_cnt    enabled cycles since reset (0 when counter not built)
// -----------------------------------------------------------------------------
module pipe_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_enable,
    input  logic                     i_in_valid,
    input  logic [DATA_W-1:0]        i_in_data,
    input  logic                     i_in_halt,
    input  logic [STAGES-1:0]        i_stall,
    input  logic [STAGES-1:0]        i_flush,
    output logic                     o_in_ready,
    output logic [STAGES-1:0]        o_stage_valid,
    output logic [STAGES*DATA_W-1:0] o_stage_data,
    output logic                     o_out_valid,
    output logic [DATA_W-1:0]        o_out_data,
    output logic                     o_drained,
    output logic                     o_halt,
    output logic [CNT_W-1:0]         o_cycle_cnt
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_halt;
    logic [DATA_W-1:0] r_data [STAGES];
    logic              r_halted;

    logic [STAGES-1:0] w_hold;
    logic              w_in_ready;
    logic              w_halt_exit;

    // hold[k] = OR of stall[j] for j >= k, accumulated from the output end.
    always_comb begin
        logic w_acc;
        w_acc  = 1'b0;
        w_hold = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_acc                 = w_acc | i_stall[STAGES-1-i];
            w_hold[STAGES-1-i]    = w_acc;
        end
    end

    // No new input while a halt marker is anywhere in the chain or has exited.
    assign w_in_ready  = i_enable & ~w_hold[0] & ~i_flush[0] & ~(|r_halt) & ~r_halted;
    assign w_halt_exit = i_enable & r_valid[STAGES-1] & r_halt[STAGES-1] & ~i_stall[STAGES-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid  <= '0;
            r_halt   <= '0;
            r_halted <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else if (i_enable) begin
            // Stage 0: flush > hold > load from the input port.
            if (i_flush[0]) begin
                r_valid[0] <= 1'b0;
                r_halt[0]  <= 1'b0;
            end else if (!w_hold[0]) begin
                r_valid[0] <= i_in_valid & w_in_ready;
                r_data[0]  <= i_in_data;
                r_halt[0]  <= i_in_halt & i_in_valid & w_in_ready;
            end

            // Stages 1..N-1: flush > hold > bubble behind a stalled stage > load.
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (i_flush[k]) begin
                    r_valid[k] <= 1'b0;
                    r_halt[k]  <= 1'b0;
                end else if (!w_hold[k]) begin
                    if (i_stall[k-1]) begin
                        r_valid[k] <= 1'b0;
                        r_halt[k]  <= 1'b0;
                    end else begin
                        r_valid[k] <= r_valid[k-1];
                        r_halt[k]  <= r_halt[k-1];
                        r_data[k]  <= r_data[k-1];
                    end
                end
            end

            if (w_halt_exit) begin
                r_halted <= 1'b1;
            end
        end
    end

`ifdef PIPE_CHAIN_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cycle_cnt <= '0;
        end else if (i_enable && !r_halted) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`else
    assign o_cycle_cnt = '0;
`endif

    always_comb begin
        o_stage_data = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            o_stage_data[k*DATA_W +: DATA_W] = r_data[k];
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_stage_valid = r_valid;
    assign o_out_valid   = r_valid[STAGES-1];
    assign o_out_data    = r_data[STAGES-1];
    assign o_drained     = ~(|r_valid);
    assign o_halt        = r_halted;

endmodule

// File: tb/tb_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain
//   Self-checking bench for pipe_chain (DATA_W=32, STAGES=4, CNT_W=32).
//   A negedge scoreboard records accepted payloads and checks the order in
//   which they leave the last stage; each scenario task adds its own timing
//   and state checks.
// -----------------------------------------------------------------------------
module tb_pipe_chain;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_enable;
    logic         i_in_valid;
    logic [31:0]  i_in_data;
    logic         i_in_halt;
    logic [3:0]   i_stall;
    logic [3:0]   i_flush;
    logic         o_in_ready;
    logic [3:0]   o_stage_valid;
    logic [127:0] o_stage_data;
    logic         o_out_valid;
    logic [31:0]  o_out_data;
    logic         o_drained;
    logic         o_halt;
    logic [31:0]  o_cycle_cnt;

    pipe_chain #(
        .DATA_W (32),
        .STAGES (4),
        .CNT_W  (32)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_enable      (i_enable),
        .i_in_valid    (i_in_valid),
        .i_in_data     (i_in_data),
        .i_in_halt     (i_in_halt),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .o_in_ready    (o_in_ready),
        .o_stage_valid (o_stage_valid),
        .o_stage_data  (o_stage_data),
        .o_out_valid   (o_out_valid),
        .o_out_data    (o_out_data),
        .o_drained     (o_drained),
        .o_halt        (o_halt),
        .o_cycle_cnt   (o_cycle_cnt)
    );

    always #5 i_clk = ~i_clk;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    bit          sb_on      = 1'b0;
    int unsigned exp_cnt    = 0;
    bit          cnt_frozen = 1'b0;

    // Scoreboard: push on acceptance, pop/compare when the last stage advances.
    always @(negedge i_clk) begin
        logic [31:0] exp_v;
        if (sb_on && i_reset_n) begin
            if (o_out_valid && i_enable && !i_stall[3] && !i_flush[3]) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_extra: got %0d, required no output", o_out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (o_out_data !== exp_v) begin
                        miscompares++;
                        $display("FAIL sb_order: got %0d, required %0d", o_out_data, exp_v);
                    end
                end
            end
            if (o_in_ready && i_in_valid) exp_q.push_back(i_in_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        if (i_reset_n && i_enable && !cnt_frozen) exp_cnt++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic h,
                         input logic [3:0] st, input logic [3:0] fl);
        i_in_valid = v;
        i_in_data  = d;
        i_in_halt  = h;
        i_stall    = st;
        i_flush    = fl;
    endtask

    function automatic logic [31:0] cnt_model();
`ifdef PIPE_CHAIN_CYCLE_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_enable  = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0);
        @(posedge i_clk);
        #1;
        vectors++; if (o_stage_valid !== 4'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0000", o_stage_valid); end
        vectors++; if (o_stage_data !== 128'd0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", o_stage_data); end
        vectors++; if (o_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", o_out_valid); end
        vectors++; if (o_drained !== 1'b1) begin miscompares++; $display("FAIL rst_drained: got %b, required 1", o_drained); end
        vectors++; if (o_halt !== 1'b0) begin miscompares++; $display("FAIL rst_halt: got %b, required 0", o_halt); end
        vectors++; if (o_cycle_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d, required 0", o_cycle_cnt); end
        vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 1", o_in_ready); end
        i_reset_n  = 1'b1;
        exp_cnt    = 0;
        cnt_frozen = 1'b0;
    endtask

    task automatic test_stream();
        sb_on = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            if (t <= 8) drive(1'b1, 32'(t), 1'b0, 4'b0, 4'b0);
            else        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0);
            tick();
            if (t >= 4 && t <= 11) begin
                vectors++; if (o_out_valid !== 1'b1 || o_out_data !== 32'(t - 3)) begin
                    miscompares++; $display("FAIL stream_out t=%0d: got v=%b d=%0d, required v=1 d=%0d", t, o_out_valid, o_out_data, t - 3);
                end
            end else begin
                vectors++; if (o_out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL stream_idle t=%0d: got v=%b, required 0", t, o_out_valid);
                end
            end
        end
        vectors++; if (o_drained !== 1'b1 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL stream_drain: got drained=%b pending=%0d, required 1 and 0", o_drained, exp_q.size());
        end
    endtask

    task automatic test_stall();
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, 32'(10 + t), 1'b0, 4'b0, 4'b0);
            tick();
        end
        vectors++; if (o_stage_valid !== 4'hF) begin miscompares++; $display("FAIL stall_full: got %b, required 1111", o_stage_valid); end
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 32'd15, 1'b0, 4'b0100, 4'b0);
            #1;
            vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready s=%0d: got %b, required 0", s, o_in_ready); end
            tick();
            vectors++; if (o_stage_valid !== 4'b0111) begin miscompares++; $display("FAIL stall_bubble s=%0d: got %b, required 0111", s, o_stage_valid); end
            vectors++; if (o_stage_data[95:0] !== {32'd12, 32'd13, 32'd14}) begin
                miscompares++; $display("FAIL stall_frozen s=%0d: got %h, required 0000000c0000000d0000000e", s, o_stage_data[95:0]);
            end
        end
        drive(1'b1, 32'd15, 1'b0, 4'b0, 4'b0);
        #1;
        vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b, required 1", o_in_ready); end
        tick();
        vectors++; if (o_out_valid !== 1'b1 || o_out_data !== 32'd12) begin
            miscompares++; $display("FAIL stall_release_out: got v=%b d=%0d, required v=1 d=12", o_out_valid, o_out_data);
        end
        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0);
        for (int i = 0; i < 12 && !o_drained; i++) tick();
        vectors++; if (o_drained !== 1'b1 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL stall_drain: got drained=%b pending=%0d, required 1 and 0", o_drained, exp_q.size());
        end
    endtask

    task automatic test_flush_stall();
        sb_on = 1'b0;
        drive(1'b1, 32'd21, 1'b0, 4'b0, 4'b0);
        tick();
        drive(1'b1, 32'd22, 1'b0, 4'b0, 4'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 4'b0010, 4'b0010);
        #1;
        vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL fs_ready: got %b, required 0", o_in_ready); end
        tick();
        vectors++; if (o_stage_valid !== 4'b0001) begin miscompares++; $display("FAIL fs_valid: got %b, required 0001", o_stage_valid); end
        vectors++; if (o_stage_data[31:0] !== 32'd22) begin miscompares++; $display("FAIL fs_hold0: got %0d, required 22", o_stage_data[31:0]); end
        vectors++; if (o_stage_data[63:32] !== 32'd21) begin miscompares++; $display("FAIL fs_data1: got %0d, required 21", o_stage_data[63:32]); end
        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0);
        tick();
        tick();
        vectors++; if (o_out_valid !== 1'b0) begin miscompares++; $display("FAIL fs_early: got %b, required 0", o_out_valid); end
        tick();
        vectors++; if (o_out_valid !== 1'b1 || o_out_data !== 32'd22) begin
            miscompares++; $display("FAIL fs_late: got v=%b d=%0d, required v=1 d=22", o_out_valid, o_out_data);
        end
        for (int i = 0; i < 12 && !o_drained; i++) tick();
        vectors++; if (o_drained !== 1'b1) begin miscompares++; $display("FAIL fs_drain: got %b, required 1", o_drained); end
    endtask

    task automatic test_flush_halt();
        sb_on = 1'b0;
        drive(1'b1, 32'd31, 1'b1, 4'b0, 4'b0);
        tick();
        drive(1'b1, 32'd32, 1'b0, 4'b0, 4'b0);
        #1;
        vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL fh_blocked: got %b, required 0", o_in_ready); end
        tick();
        // Marker now in stage 1; flushing stage 2 on this edge discards it.
        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0100);
        tick();
        vectors++; if (o_stage_valid !== 4'b0) begin miscompares++; $display("FAIL fh_valid: got %b, required 0000", o_stage_valid); end
        drive(1'b1, 32'd33, 1'b0, 4'b0, 4'b0);
        #1;
        vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL fh_resume: got %b, required 1", o_in_ready); end
        tick();
        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0);
        for (int i = 0; i < 12 && !o_drained; i++) tick();
        vectors++; if (o_drained !== 1'b1 || o_halt !== 1'b0) begin
            miscompares++; $display("FAIL fh_end: got drained=%b halt=%b, required 1 and 0", o_drained, o_halt);
        end
    endtask

    task automatic test_halt();
        sb_on = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            drive(1'b1, 32'(t), (t == 5), 4'b0, 4'b0);
            #1;
            vectors++; if (o_in_ready !== (t <= 5)) begin
                miscompares++; $display("FAIL halt_ready t=%0d: got %b, required %b", t, o_in_ready, (t <= 5));
            end
            tick();
            if (t == 8) begin
                vectors++; if (o_halt !== 1'b0 || o_drained !== 1'b0) begin
                    miscompares++; $display("FAIL halt_early: got halt=%b drained=%b, required 0 and 0", o_halt, o_drained);
                end
            end
            if (t == 9) begin
                cnt_frozen = 1'b1;
                vectors++; if (o_halt !== 1'b1 || o_drained !== 1'b1) begin
                    miscompares++; $display("FAIL halt_set: got halt=%b drained=%b, required 1 and 1", o_halt, o_drained);
                end
            end
        end
        vectors++; if (o_halt !== 1'b1 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL halt_sticky: got halt=%b pending=%0d, required 1 and 0", o_halt, exp_q.size());
        end
        vectors++; if (o_cycle_cnt !== cnt_model()) begin
            miscompares++; $display("FAIL halt_cnt: got %0d, required %0d", o_cycle_cnt, cnt_model());
        end
    endtask

    task automatic test_async_reset();
        i_reset_n = 1'b0;
        #1;
        vectors++; if (o_halt !== 1'b0) begin miscompares++; $display("FAIL ar_halt_clear: got %b, required 0", o_halt); end
        @(posedge i_clk);
        #1;
        i_reset_n  = 1'b1;
        exp_cnt    = 0;
        cnt_frozen = 1'b0;
        exp_q.delete();
        sb_on = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            i_enable = (t % 2 == 1);
            drive(1'b1, 32'(40 + t), 1'b0, 4'b0, 4'b0);
            #1;
            if (!i_enable) begin
                vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL ar_dis_ready t=%0d: got %b, required 0", t, o_in_ready); end
            end
            tick();
        end
        vectors++; if (o_stage_valid !== 4'hF || o_out_data !== 32'd41 || o_stage_data[31:0] !== 32'd47) begin
            miscompares++; $display("FAIL ar_enable_gate: got v=%b out=%0d s0=%0d, required 1111 41 47", o_stage_valid, o_out_data, o_stage_data[31:0]);
        end
        vectors++; if (o_cycle_cnt !== cnt_model()) begin
            miscompares++; $display("FAIL ar_cnt: got %0d, required %0d", o_cycle_cnt, cnt_model());
        end
        i_enable = 1'b1;
        drive(1'b1, 32'd50, 1'b0, 4'b1000, 4'b0);
        #1;
        sb_on     = 1'b0;
        i_reset_n = 1'b0;
        #1;
        vectors++; if (o_stage_valid !== 4'b0 || o_stage_data !== 128'd0) begin
            miscompares++; $display("FAIL ar_stages: got v=%b d=%h, required 0 and 0", o_stage_valid, o_stage_data);
        end
        vectors++; if (o_out_valid !== 1'b0 || o_out_data !== 32'd0 || o_drained !== 1'b1) begin
            miscompares++; $display("FAIL ar_out: got v=%b d=%0d drained=%b, required 0 0 1", o_out_valid, o_out_data, o_drained);
        end
        vectors++; if (o_halt !== 1'b0 || o_cycle_cnt !== 32'd0) begin
            miscompares++; $display("FAIL ar_halt_cnt: got halt=%b cnt=%0d, required 0 0", o_halt, o_cycle_cnt);
        end
        exp_q.delete();
        drive(1'b0, 32'd0, 1'b0, 4'b0, 4'b0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_stall();
        test_flush_halt();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
